vga_scan_gen: RTL



---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_axis_counter.sv | 37 +++
 rtl/vga_scan_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for vga_scan_gen: 640x480 timing, colour constants,
// coordinate width and scan FSM states.
package vga_pkg;

  localparam int COORD_W     = 11;
  localparam int COLOR_W     = 30;
  localparam int FRAME_CNT_W = 16;

  localparam int H_ACTIVE_640 = 640;
  localparam int H_FP_640     = 16;
  localparam int H_SYNC_640   = 96;
  localparam int H_BP_640     = 48;
  localparam int V_ACTIVE_640 = 480;
  localparam int V_FP_640     = 10;
  localparam int V_SYNC_640   = 2;
  localparam int V_BP_640     = 33;

  localparam logic [COLOR_W-1:0] COLOR_WHITE = 30'h3FFFFFFF;
  localparam logic [COLOR_W-1:0] COLOR_BLACK = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    STOP = 2'd2
  } scan_state_t;

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_640 = axis_total(H_ACTIVE_640, H_FP_640, H_SYNC_640, H_BP_640);
  localparam int V_TOTAL_640 = axis_total(V_ACTIVE_640, V_FP_640, V_SYNC_640, V_BP_640);

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: wrapping counter with increment enable, terminal-count flag,
// active-area decode and sync window decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE     = H_ACTIVE_640,
  parameter int TOTAL      = H_TOTAL_640,
  parameter int SYNC_START = H_ACTIVE_640 + H_FP_640,
  parameter int SYNC_END   = H_ACTIVE_640 + H_FP_640 + H_SYNC_640
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [COORD_W-1:0] count,
  output logic               tc,
  output logic               active,
  output logic               sync_win
);

  localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACT_LIM  = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_LO  = COORD_W'(SYNC_START);
  localparam logic [COORD_W-1:0] SYNC_HI  = COORD_W'(SYNC_END);

  assign tc       = (count == LAST);
  assign active   = (count < ACT_LIM);
  assign sync_win = (count >= SYNC_LO) && (count < SYNC_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + COORD_W'(1);
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: counters, sync, start/stop FSM and delay matching
// around an external one-clock colour block. Optional border: VGA_BORDER_EN.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_640,
  parameter int H_FP     = H_FP_640,
  parameter int H_SYNC   = H_SYNC_640,
  parameter int H_BP     = H_BP_640,
  parameter int V_ACTIVE = V_ACTIVE_640,
  parameter int V_FP     = V_FP_640,
  parameter int V_SYNC   = V_SYNC_640,
  parameter int V_BP     = V_BP_640,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic [COLOR_W-1:0]     color_data,
  output logic [COORD_W-1:0]     x,
  output logic [COORD_W-1:0]     y,
  output logic                   enable,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [COLOR_W-1:0]     rgb,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  scan_state_t        state, state_next;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_tc, v_tc, h_act, v_act, h_win, v_win;
  logic               count_en, frame_end;
  logic               hs_a, vs_a;
  logic               hs_b, vs_b, en_b;
  logic [COLOR_W-1:0] rgb_next;

  // Counting also runs on the IDLE cycle that samples run, so (0,0) appears on the next edge.
  assign count_en  = (state != IDLE) || run;
  assign frame_end = (state != IDLE) && h_tc && v_tc;
  assign busy      = (state != IDLE);

  vga_axis_counter #(
    .ACTIVE    (H_ACTIVE),
    .TOTAL     (H_TOTAL),
    .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END  (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (count_en),
    .count   (h_cnt),
    .tc      (h_tc),
    .active  (h_act),
    .sync_win(h_win)
  );

  vga_axis_counter #(
    .ACTIVE    (V_ACTIVE),
    .TOTAL     (V_TOTAL),
    .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END  (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (count_en && h_tc),
    .count   (v_cnt),
    .tc      (v_tc),
    .active  (v_act),
    .sync_win(v_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (run) state_next = SCAN;
      SCAN: if (!run) state_next = frame_end ? IDLE : STOP;
      STOP: begin
        if (run) state_next = SCAN;
        else if (frame_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      enable      <= 1'b0;
      hs_a        <= 1'b0;
      vs_a        <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      x           <= h_cnt;
      y           <= v_cnt;
      enable      <= count_en && h_act && v_act;
      hs_a        <= count_en && h_win;
      vs_a        <= count_en && v_win;
      frame_start <= count_en && (h_cnt == '0) && (v_cnt == '0);
      if (frame_end) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Stage B lines up with the colour block's register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_b <= 1'b0;
      vs_b <= 1'b0;
      en_b <= 1'b0;
    end else begin
      hs_b <= hs_a;
      vs_b <= vs_a;
      en_b <= enable;
    end
  end

`ifdef VGA_BORDER_EN
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  logic [COORD_W-1:0] x_b, y_b;
  logic               border_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_b <= '0;
      y_b <= '0;
    end else begin
      x_b <= x;
      y_b <= y;
    end
  end

  assign border_b = en_b && ((x_b == '0) || (x_b == X_LAST) ||
                             (y_b == '0) || (y_b == Y_LAST));
  assign rgb_next = border_b ? COLOR_WHITE : (en_b ? color_data : COLOR_BLACK);
`else
  assign rgb_next = en_b ? color_data : COLOR_BLACK;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      rgb   <= COLOR_BLACK;
    end else begin
      hsync <= hs_b ? HS_POL : ~HS_POL;
      vsync <= vs_b ? VS_POL : ~VS_POL;
      de    <= en_b;
      rgb   <= rgb_next;
    end
  end

endmodule
